branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor_pkg.sv | 29 ++
 rtl/branch_predictor_sat_counter.sv | 41 ++++
 rtl/branch_predictor.sv | 127 ++++++++++++
 tb/tb_branch_predictor.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared CPU package: branch predictor defaults, table geometry helpers and
// the predictor entry record.
package branch_predictor_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned ENTRIES_DEF  = 64;
  localparam int unsigned CTR_BITS_DEF = 2;

  // Index bits taken from PC[IDX+1:2]; ENTRIES is a power of two.
  function automatic int unsigned idx_width(input int unsigned entries);
    return $clog2(entries);
  endfunction

  // Tag bits are everything above the index and the word offset.
  function automatic int unsigned tag_width(input int unsigned xlen, input int unsigned entries);
    return xlen - idx_width(entries) - 2;
  endfunction

  localparam int unsigned TAG_W_DEF = tag_width(XLEN_DEF, ENTRIES_DEF);

  // Entry record for the default geometry (used by debug/trace consumers).
  // The counter lives in its own sat_counter instance, not in this record.
  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [XLEN_DEF-3:0]   target;  // word-aligned target, PC[XLEN-1:2]
  } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down counter with synchronous reset and parallel load.
// Priority: reset > load > inc > dec. Never wraps.
module sat_counter #(
  parameter int unsigned     W       = 2,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] MAX_VAL = '1;

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: load wins, otherwise step toward the requested bound and hold there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      if (count_q != MAX_VAL) count_d = count_q + 1'b1;
    end else if (dec_i) begin
      if (count_q != '0) count_d = count_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters and a saturating mispredict counter.
//
// Update interface: upd_valid_i qualifies upd_* for exactly one cycle; there is
// no ready, every valid update is accepted on the rising edge it is presented.
// Lookup is purely combinational and sees the table as it was before any
// update presented in the same cycle (no bypass).
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned ENTRIES  = ENTRIES_DEF,
  parameter int unsigned CTR_BITS = CTR_BITS_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            pred_hit_o,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_next_pc_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_mispred_i,
  output logic [31:0]     mispred_cnt_o
);

  localparam int unsigned IDX_W = idx_width(ENTRIES);
  localparam int unsigned TAG_W = tag_width(XLEN, ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic [ENTRIES-1:0]  valid_d, valid_q;
  logic [TAG_W-1:0]    tag_d    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-3:0]     target_d [ENTRIES];
  logic [XLEN-3:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_val  [ENTRIES];

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             upd_hit, alloc;

  assign lk_idx  = lookup_pc_i[IDX_W+1:2];
  assign lk_tag  = lookup_pc_i[XLEN-1:IDX_W+2];
  assign upd_idx = upd_pc_i[IDX_W+1:2];
  assign upd_tag = upd_pc_i[XLEN-1:IDX_W+2];

  // Byte-offset bits of the update PC/target carry no information.
  logic unused_low_bits;
  assign unused_low_bits = ^{upd_pc_i[1:0], upd_target_i[1:0]};

  // Classify the update: hit trains the counter, taken miss allocates.
  always_comb begin
    upd_hit = upd_valid_i && valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    alloc   = upd_valid_i && !upd_hit && upd_taken_i;
  end

  // Prediction from current table state only.
  always_comb begin
    pred_hit_o     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o   = pred_hit_o && ctr_val[lk_idx][CTR_BITS-1];
    pred_next_pc_o = pred_taken_o ? {target_q[lk_idx], 2'b00}
                                  : lookup_pc_i + XLEN'(4);
  end

  // Table write: any taken update (hit or allocate) refreshes the target;
  // only an allocation writes the tag and sets valid.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (alloc) begin
      valid_d[upd_idx] = 1'b1;
      tag_d[upd_idx]   = upd_tag;
    end
    if (upd_valid_i && upd_taken_i) begin
      target_d[upd_idx] = upd_target_i[XLEN-1:2];
    end
  end

  // Valid bits are reset; reset overrides any simultaneous update.
  always_ff @(posedge clk_i) begin
    if (rst_i) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag/target storage is not reset: meaningless while the entry is invalid.
  always_ff @(posedge clk_i) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  // One direction counter per entry.
  for (genvar i = 0; i < ENTRIES; i++) begin : gen_ctr
    logic sel;
    assign sel = (upd_idx == IDX_W'(i));
    sat_counter #(
      .W       (CTR_BITS),
      .RST_VAL (CTR_WEAK_NT)
    ) u_ctr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (alloc && sel),
      .load_val_i (CTR_WEAK_T),
      .inc_i      (upd_hit && sel && upd_taken_i),
      .dec_i      (upd_hit && sel && !upd_taken_i),
      .count_o    (ctr_val[i])
    );
  end

  // Mispredict counter: counts only, never influences table updates.
  sat_counter #(
    .W       (32),
    .RST_VAL ('0)
  ) u_mispred_ctr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .inc_i      (upd_valid_i && upd_mispred_i),
    .dec_i      (1'b0),
    .count_o    (mispred_cnt_o)
  );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: default geometry (dut_a) and
// ENTRIES=4 / CTR_BITS=3 (dut_b) sharing clock and reset.
module tb_branch_predictor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic [31:0] a_lookup_pc = '0;
  logic        a_hit, a_taken;
  logic [31:0] a_next;
  logic        a_upd_valid = 1'b0;
  logic [31:0] a_upd_pc = '0;
  logic        a_upd_taken = 1'b0;
  logic [31:0] a_upd_target = '0;
  logic        a_upd_mispred = 1'b0;
  logic [31:0] a_mis;

  // ---------------- dut_b signals ----------------
  logic [31:0] b_lookup_pc = '0;
  logic        b_hit, b_taken;
  logic [31:0] b_next;
  logic        b_upd_valid = 1'b0;
  logic [31:0] b_upd_pc = '0;
  logic        b_upd_taken = 1'b0;
  logic [31:0] b_upd_target = '0;
  logic        b_upd_mispred = 1'b0;
  logic [31:0] b_mis;

  branch_predictor dut_a (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(a_lookup_pc),
    .pred_hit_o(a_hit), .pred_taken_o(a_taken), .pred_next_pc_o(a_next),
    .upd_valid_i(a_upd_valid), .upd_pc_i(a_upd_pc), .upd_taken_i(a_upd_taken),
    .upd_target_i(a_upd_target), .upd_mispred_i(a_upd_mispred),
    .mispred_cnt_o(a_mis)
  );

  branch_predictor #(.XLEN(32), .ENTRIES(4), .CTR_BITS(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .lookup_pc_i(b_lookup_pc),
    .pred_hit_o(b_hit), .pred_taken_o(b_taken), .pred_next_pc_o(b_next),
    .upd_valid_i(b_upd_valid), .upd_pc_i(b_upd_pc), .upd_taken_i(b_upd_taken),
    .upd_target_i(b_upd_target), .upd_mispred_i(b_upd_mispred),
    .mispred_cnt_o(b_mis)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change just after the falling edge; outputs are checked 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic a_update(input logic [31:0] pc, input logic taken,
                          input logic [31:0] tgt, input logic mis);
    a_upd_valid = 1'b1; a_upd_pc = pc; a_upd_taken = taken;
    a_upd_target = tgt; a_upd_mispred = mis;
    cycle();
    a_upd_valid = 1'b0; a_upd_mispred = 1'b0;
  endtask

  task automatic b_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    b_upd_valid = 1'b1; b_upd_pc = pc; b_upd_taken = taken;
    b_upd_target = tgt; b_upd_mispred = 1'b0;
    cycle();
    b_upd_valid = 1'b0;
  endtask

  task automatic a_look(input logic [31:0] pc);
    a_lookup_pc = pc;
    #1;
  endtask

  task automatic b_look(input logic [31:0] pc);
    b_lookup_pc = pc;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // reset
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // A: post-reset lookup
    a_look(32'h0000_0040);
    check("a_rst_hit",   {31'b0, a_hit},   32'h0);
    check("a_rst_taken", {31'b0, a_taken}, 32'h0);
    check("a_rst_next",  a_next,           32'h0000_0044);
    check("a_rst_mis",   a_mis,            32'h0);
    check("a_rst_ctr",   32'(dut_a.ctr_val[16]), 32'd1);
    a_look(32'hFFFF_FFFC);
    check("a_next_wrap", a_next, 32'h0000_0000);

    // A: allocate 0x40 -> 0x100; lookup in the same cycle sees the old entry
    a_upd_valid = 1'b1; a_upd_pc = 32'h40; a_upd_taken = 1'b1;
    a_upd_target = 32'h100; a_upd_mispred = 1'b1;
    a_look(32'h0000_0040);
    check("a_same_cycle_hit", {31'b0, a_hit}, 32'h0);
    cycle();
    a_upd_valid = 1'b0; a_upd_mispred = 1'b0;
    a_look(32'h0000_0040);
    check("a_alloc_hit",   {31'b0, a_hit},   32'h1);
    check("a_alloc_taken", {31'b0, a_taken}, 32'h1);
    check("a_alloc_next",  a_next,           32'h0000_0100);
    check("a_alloc_ctr",   32'(dut_a.ctr_val[16]), 32'd2);
    check("a_mis_one",     a_mis,            32'd1);

    // A: taken hits increment, refresh target, saturate at 3
    a_update(32'h40, 1'b1, 32'h200, 1'b0);
    a_look(32'h40);
    check("a_inc_ctr",  32'(dut_a.ctr_val[16]), 32'd3);
    check("a_inc_next", a_next, 32'h0000_0200);
    a_update(32'h40, 1'b1, 32'h104, 1'b0);
    a_look(32'h40);
    check("a_sat_hi_ctr",  32'(dut_a.ctr_val[16]), 32'd3);
    check("a_sat_hi_next", a_next, 32'h0000_0104);

    // A: not-taken hits decrement, saturate at 0
    a_update(32'h40, 1'b0, 32'h0, 1'b0);
    a_update(32'h40, 1'b0, 32'h0, 1'b0);
    a_look(32'h40);
    check("a_dec1_ctr",   32'(dut_a.ctr_val[16]), 32'd1);
    check("a_dec1_hit",   {31'b0, a_hit},   32'h1);
    check("a_dec1_taken", {31'b0, a_taken}, 32'h0);
    check("a_dec1_next",  a_next,           32'h0000_0044);
    a_update(32'h40, 1'b0, 32'h0, 1'b0);
    a_look(32'h40);
    check("a_dec0_ctr", 32'(dut_a.ctr_val[16]), 32'd0);
    a_update(32'h40, 1'b0, 32'h0, 1'b0);
    a_look(32'h40);
    check("a_sat_lo_ctr", 32'(dut_a.ctr_val[16]), 32'd0);

    // A: not-taken miss does not allocate
    a_update(32'h80, 1'b0, 32'h400, 1'b0);
    a_look(32'h80);
    check("a_nt_miss_hit", {31'b0, a_hit}, 32'h0);

    // A: update inputs ignored without upd_valid_i
    a_upd_valid = 1'b0; a_upd_pc = 32'hC0; a_upd_taken = 1'b1;
    a_upd_target = 32'h500; a_upd_mispred = 1'b1;
    cycle();
    a_upd_mispred = 1'b0;
    a_look(32'hC0);
    check("a_novalid_hit", {31'b0, a_hit}, 32'h0);
    check("a_novalid_mis", a_mis, 32'd1);

    // A: alias 0x140 evicts 0x40, counter reloaded to weakly taken
    a_update(32'h140, 1'b1, 32'h300, 1'b0);
    a_look(32'h40);
    check("a_evict_hit",  {31'b0, a_hit}, 32'h0);
    check("a_evict_next", a_next, 32'h0000_0044);
    a_look(32'h140);
    check("a_alias_hit",  {31'b0, a_hit}, 32'h1);
    check("a_alias_next", a_next, 32'h0000_0300);
    check("a_alias_ctr",  32'(dut_a.ctr_val[16]), 32'd2);

    // A: mispredict counter saturation from a preloaded value
    force dut_a.u_mispred_ctr.count_q = 32'hFFFF_FFFE;
    cycle();
    release dut_a.u_mispred_ctr.count_q;
    #1;
    check("a_mis_preload", a_mis, 32'hFFFF_FFFE);
    a_update(32'h80, 1'b0, 32'h0, 1'b1);
    #1;
    check("a_mis_max", a_mis, 32'hFFFF_FFFF);
    a_update(32'h80, 1'b0, 32'h0, 1'b1);
    a_update(32'h80, 1'b0, 32'h0, 1'b1);
    a_look(32'h140);
    check("a_mis_sat", a_mis, 32'hFFFF_FFFF);
    check("a_mis_table_kept", {31'b0, a_hit}, 32'h1);

    // A: reset wins over a simultaneous allocating, mispredicted update
    rst = 1'b1;
    a_update(32'h40, 1'b1, 32'h600, 1'b1);
    rst = 1'b0;
    a_look(32'h140);
    check("a_rst2_mis",     a_mis, 32'h0);
    check("a_rst2_hit140",  {31'b0, a_hit}, 32'h0);
    a_look(32'h40);
    check("a_rst2_hit40",   {31'b0, a_hit}, 32'h0);
    check("a_rst2_next40",  a_next, 32'h0000_0044);
    check("a_rst2_ctr",     32'(dut_a.ctr_val[16]), 32'd1);

    // B (ENTRIES=4, CTR_BITS=3): reset state
    b_look(32'h40);
    check("b_rst_ctr",  32'(dut_b.ctr_val[0]), 32'd3);
    check("b_rst_hit",  {31'b0, b_hit}, 32'h0);
    check("b_rst_next", b_next, 32'h0000_0044);

    // B: allocation loads 4
    b_update(32'h40, 1'b1, 32'h80);
    b_look(32'h40);
    check("b_alloc_ctr",   32'(dut_b.ctr_val[0]), 32'd4);
    check("b_alloc_taken", {31'b0, b_taken}, 32'h1);
    check("b_alloc_next",  b_next, 32'h0000_0080);

    // B: saturate at 7
    for (int i = 0; i < 4; i++) b_update(32'h40, 1'b1, 32'h80);
    b_look(32'h40);
    check("b_sat_hi_ctr", 32'(dut_b.ctr_val[0]), 32'd7);

    // B: four decrements -> 3, MSB clear
    for (int i = 0; i < 4; i++) b_update(32'h40, 1'b0, 32'h0);
    b_look(32'h40);
    check("b_dec3_ctr",   32'(dut_b.ctr_val[0]), 32'd3);
    check("b_dec3_taken", {31'b0, b_taken}, 32'h0);
    check("b_dec3_next",  b_next, 32'h0000_0044);

    // B: saturate at 0
    for (int i = 0; i < 4; i++) b_update(32'h40, 1'b0, 32'h0);
    b_look(32'h40);
    check("b_sat_lo_ctr", 32'(dut_b.ctr_val[0]), 32'd0);
    check("b_sat_lo_hit", {31'b0, b_hit}, 32'h1);

    // B: alias 0x50 (same index 0, different tag) evicts 0x40
    b_update(32'h50, 1'b1, 32'h90);
    b_look(32'h40);
    check("b_evict_hit", {31'b0, b_hit}, 32'h0);
    b_look(32'h50);
    check("b_alias_next", b_next, 32'h0000_0090);
    check("b_mis",        b_mis, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
